// File: rtl/div_sched.sv
// div_sched: round-robin scheduler feeding four requesters into one shared 32/16 restoring divider.
// Build option: define DIV_SCHED_RADIX4_EN to retire two quotient bits per cycle instead of one.
module div_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] req_dividend,
  input  logic [63:0]  req_divisor,
  output logic [3:0]   grant,
  output logic [3:0]   done,
  output logic [31:0]  quotient,
  output logic [15:0]  remainder,
  output logic         div_by_zero,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef DIV_SCHED_RADIX4_EN
  localparam logic [4:0] CNT_INIT = 5'd15;
`else
  localparam logic [4:0] CNT_INIT = 5'd31;
`endif

  state_t      state_q;
  logic [3:0]  grant_q;
  logic [3:0]  done_q;
  logic [3:0]  owner_q;
  logic [1:0]  last_q;
  logic [31:0] acc_q;
  logic [16:0] prem_q;
  logic [15:0] dvs_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q;
  logic [15:0] rem_q;
  logic        dbz_q;

  logic [3:0]  elig;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [16:0] prem_1;
  logic [31:0] acc_1;
  logic [16:0] prem_d;
  logic [31:0] acc_d;

  // One restoring step: shift in the next dividend bit, subtract, keep the difference if no borrow.
  function automatic logic [48:0] div_step(input logic [16:0] p, input logic [31:0] a,
                                           input logic [15:0] d);
    logic [17:0] trial;
    logic [17:0] diff;
    trial = {p, a[31]};
    diff  = trial - {2'b00, d};
    if (diff[17]) return {trial[16:0], a[30:0], 1'b0};
    else          return {diff[16:0], a[30:0], 1'b1};
  endfunction

  assign {prem_1, acc_1} = div_step(prem_q, acc_q, dvs_q);
`ifdef DIV_SCHED_RADIX4_EN
  assign {prem_d, acc_d} = div_step(prem_1, acc_1, dvs_q);
`else
  assign prem_d = prem_1;
  assign acc_d  = acc_1;
`endif

  // The requester whose result is being presented cannot win again in the same cycle.
  always_comb begin
    elig      = (state_q == S_DONE) ? (req & ~done_q) : req;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_valid && elig[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= 2'd3;
      acc_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (win_valid) begin
            acc_q   <= req_dividend[{win_idx, 5'd0} +: 32];
            dvs_q   <= req_divisor[{win_idx, 4'd0} +: 16];
            prem_q  <= '0;
            cnt_q   <= CNT_INIT;
            owner_q <= 4'b0001 << win_idx;
            grant_q <= 4'b0001 << win_idx;
            last_q  <= win_idx;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (dvs_q == '0) begin
            // Zero divisor: acc_q still holds the untouched dividend on the first RUN cycle.
            quo_q   <= '1;
            rem_q   <= acc_q[15:0];
            dbz_q   <= 1'b1;
            done_q  <= owner_q;
            state_q <= S_DONE;
          end else begin
            acc_q  <= acc_d;
            prem_q <= prem_d;
            cnt_q  <= cnt_q - 5'd1;
            if (cnt_q == '0) begin
              quo_q   <= acc_d;
              rem_q   <= prem_d[15:0];
              dbz_q   <= 1'b0;
              done_q  <= owner_q;
              state_q <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed scenarios plus randomized rounds against a
// plain-arithmetic divider model and a round-robin order model.
`timescale 1ns/1ps
module tb_div_sched;

`ifdef DIV_SCHED_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] req_dividend = '0;
  logic [63:0]  req_divisor = '0;
  logic [3:0]   grant;
  logic [3:0]   done;
  logic [31:0]  quotient;
  logic [15:0]  remainder;
  logic         div_by_zero;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int onehot_viol = 0;
  int done_cnt = 0;
  logic [1:0] rr_last;
  logic [1:0] exp_q[$];

  div_sched dut (
    .clk(clk), .reset(reset), .req(req), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .grant(grant), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse-shape monitor, sampled away from the active edge
  always @(negedge clk) begin
    if ($countones(grant) > 1 || $countones(done) > 1 || (grant & done) != 4'd0)
      onehot_viol++;
    if (done != 4'd0) done_cnt++;
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic set_op(input int k, input logic [31:0] dvd, input logic [15:0] dvs);
    req_dividend[32*k +: 32] = dvd;
    req_divisor[16*k +: 16] = dvs;
  endtask

  // mode 0: wait for grant, 1: wait for done, 2: either. n = cycles waited, -1 on timeout.
  task automatic wait_sig(input int mode, input int budget, output int n,
                          output logic [3:0] g, output logic [3:0] d);
    bit hit;
    n = 0; g = '0; d = '0; hit = 0;
    while (!hit) begin
      tick();
      n++;
      g = grant;
      d = done;
      if ((mode == 0 && g != 0) || (mode == 1 && d != 0) || (mode == 2 && (g | d) != 0))
        hit = 1;
      else if (n >= budget) begin
        n = -1;
        hit = 1;
      end
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_div(input logic [31:0] dvd, input logic [15:0] dvs,
                                  output logic [31:0] q, output logic [15:0] r, output logic dz);
    if (dvs == 16'd0) begin
      q = 32'hFFFF_FFFF;
      r = dvd[15:0];
      dz = 1'b1;
    end else begin
      q = dvd / {16'd0, dvs};
      r = 16'(dvd % {16'd0, dvs});
      dz = 1'b0;
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    req = 4'hF;
    set_op(0, 32'd100, 16'd3);
    repeat (3) tick();
    n_checks++; if (grant !== 4'd0) begin n_fail++; $display("FAIL rst_grant_held: got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_held: got %b want 0", busy); end
    reset = 1'b0;
    req = '0;
    tick();
    n_checks++; if (grant !== 4'd0) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant); end
    n_checks++; if (done !== 4'd0) begin n_fail++; $display("FAIL rst_done: got %b want 0000", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL rst_quotient: got %h want 0", quotient); end
    n_checks++; if (remainder !== 16'd0) begin n_fail++; $display("FAIL rst_remainder: got %h want 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dbz: got %b want 0", div_by_zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int n; logic [3:0] g, d;
    set_op(0, 32'd64_000_000, 16'd32_000);
    req = 4'b0001;
    wait_sig(0, 8, n, g, d);
    n_checks++; if (n !== 1 || g !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b after %0d cycles want 0001 after 1", g, n); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    req = '0;
    wait_sig(1, LAT + 8, n, g, d);
    n_checks++; if (n !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", n, LAT); end
    n_checks++; if (d !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", d); end
    n_checks++; if (quotient !== 32'd2000 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL single_result: got q=%0d r=%0d dz=%b want q=2000 r=0 dz=0", quotient, remainder, div_by_zero); end
    tick();
    n_checks++; if (done !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got done=%b busy=%b want 0000 0", done, busy); end
    n_checks++; if (quotient !== 32'd2000) begin n_fail++; $display("FAIL single_hold: got %0d want 2000", quotient); end
  endtask

  task automatic test_remainder_and_run_ignore();
    int n; logic [3:0] g, d;
    set_op(2, 32'd1000, 16'd7);
    req = 4'b0100;
    wait_sig(0, 8, n, g, d);
    n_checks++; if (n !== 1 || g !== 4'b0100) begin n_fail++; $display("FAIL rem_grant: got %b after %0d want 0100 after 1", g, n); end
    req = '0;
    repeat (4) tick();
    set_op(1, 32'd100, 16'd10);
    req = 4'b0010;
    wait_sig(2, LAT + 8, n, g, d);
    n_checks++; if (n !== LAT - 4 || g !== 4'd0 || d !== 4'b0100) begin n_fail++; $display("FAIL rem_run_ignore: got grant=%b done=%b after %0d want 0000 0100 after %0d", g, d, n, LAT - 4); end
    n_checks++; if (quotient !== 32'd142 || remainder !== 16'd6 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rem_result: got q=%0d r=%0d dz=%b want 142 6 0", quotient, remainder, div_by_zero); end
    tick();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rem_b2b_grant: got %b want 0010", grant); end
    req = '0;
    wait_sig(1, LAT + 8, n, g, d);
    n_checks++; if (d !== 4'b0010 || quotient !== 32'd10 || remainder !== 16'd0) begin n_fail++; $display("FAIL rem_second: got done=%b q=%0d r=%0d want 0010 10 0", d, quotient, remainder); end
    tick();
  endtask

  task automatic test_div_zero();
    int n; logic [3:0] g, d;
    set_op(3, 32'h1234_5678, 16'd0);
    req = 4'b1000;
    wait_sig(0, 8, n, g, d);
    n_checks++; if (n !== 1 || g !== 4'b1000) begin n_fail++; $display("FAIL dz_grant: got %b after %0d want 1000 after 1", g, n); end
    req = '0;
    wait_sig(1, LAT + 8, n, g, d);
    n_checks++; if (n !== 1 || d !== 4'b1000) begin n_fail++; $display("FAIL dz_done: got %b after %0d want 1000 after 1", d, n); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 16'h5678 || div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_result: got q=%h r=%h dz=%b want ffffffff 5678 1", quotient, remainder, div_by_zero); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n, base; logic [3:0] g, d;
    set_op(1, 32'd5_000_000, 16'd3);
    req = 4'b0010;
    wait_sig(0, 8, n, g, d);
    n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL mid_grant: got %b want 0010", g); end
    req = '0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base = done_cnt;
    n_checks++; if (busy !== 1'b0 || done !== 4'd0) begin n_fail++; $display("FAIL mid_abort: got busy=%b done=%b want 0 0000", busy, done); end
    n_checks++; if (quotient !== 32'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL mid_clear: got q=%h r=%h dz=%b want 0 0 0", quotient, remainder, div_by_zero); end
    repeat (LAT + 4) tick();
    n_checks++; if (done_cnt !== base) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - base); end
    set_op(0, 32'd999, 16'd10);
    set_op(1, 32'd65536, 16'd255);
    req = 4'b0011;
    wait_sig(0, 8, n, g, d);
    n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", g); end
    req = 4'b0010;
    wait_sig(1, LAT + 8, n, g, d);
    n_checks++; if (d !== 4'b0001 || quotient !== 32'd99 || remainder !== 16'd9) begin n_fail++; $display("FAIL mid_op0: got done=%b q=%0d r=%0d want 0001 99 9", d, quotient, remainder); end
    wait_sig(0, 8, n, g, d);
    n_checks++; if (n !== 1 || g !== 4'b0010) begin n_fail++; $display("FAIL mid_second_grant: got %b after %0d want 0010 after 1", g, n); end
    req = '0;
    wait_sig(1, LAT + 8, n, g, d);
    n_checks++; if (d !== 4'b0010 || quotient !== 32'd257 || remainder !== 16'd1) begin n_fail++; $display("FAIL mid_op1: got done=%b q=%0d r=%0d want 0010 257 1", d, quotient, remainder); end
    tick();
  endtask

  task automatic test_self_reassert();
    int n; logic [3:0] g, d;
    set_op(0, 32'd77_777, 16'd100);
    req = 4'b0001;
    wait_sig(0, 8, n, g, d);
    req = '0;
    wait_sig(1, LAT + 8, n, g, d);
    n_checks++; if (d !== 4'b0001 || quotient !== 32'd777 || remainder !== 16'd77) begin n_fail++; $display("FAIL self_first: got done=%b q=%0d r=%0d want 0001 777 77", d, quotient, remainder); end
    set_op(0, 32'd1_000_000, 16'd999);
    req = 4'b0001;
    tick();
    n_checks++; if (grant !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL self_excluded: got grant=%b busy=%b want 0000 0", grant, busy); end
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL self_regrant: got %b want 0001", grant); end
    req = '0;
    wait_sig(1, LAT + 8, n, g, d);
    n_checks++; if (quotient !== 32'd1001 || remainder !== 16'd1) begin n_fail++; $display("FAIL self_second: got q=%0d r=%0d want 1001 1", quotient, remainder); end
    tick();
  endtask

  task automatic test_contention();
    int n; logic [3:0] g, d;
    logic [31:0] dvd[4]; logic [15:0] dvs[4];
    logic [31:0] eq; logic [15:0] er; logic ez;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      dvd[k] = $urandom;
      dvs[k] = 16'($urandom_range(1, 65535));
      set_op(k, dvd[k], dvs[k]);
    end
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_sig(0, LAT + 8, n, g, d);
      n_checks++; if (n !== 1 || g !== (4'b0001 << k)) begin n_fail++; $display("FAIL cont_grant%0d: got %b after %0d want %b after 1", k, g, n, 4'b0001 << k); end
      req = req & ~g;
      wait_sig(1, LAT + 8, n, g, d);
      ref_div(dvd[k], dvs[k], eq, er, ez);
      n_checks++; if (d !== (4'b0001 << k) || quotient !== eq || remainder !== er || div_by_zero !== ez) begin n_fail++; $display("FAIL cont_done%0d: got done=%b q=%h r=%h dz=%b want %b %h %h %b", k, d, quotient, remainder, div_by_zero, 4'b0001 << k, eq, er, ez); end
    end
    tick();
  endtask

  task automatic test_random();
    int n; logic [3:0] g, d, mask, eg;
    logic [1:0] idx;
    logic [31:0] dvd[4]; logic [15:0] dvs[4];
    logic [31:0] eq; logic [15:0] er; logic ez;
    int exp_lat;
    do_reset();
    rr_last = 2'd3;
    for (int rnd = 0; rnd < 14; rnd++) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) begin
        dvd[k] = $urandom;
        case ($urandom_range(0, 3))
          0: dvs[k] = 16'd0;
          1: dvs[k] = 16'($urandom_range(1, 15));
          default: dvs[k] = 16'($urandom_range(1, 65535));
        endcase
        set_op(k, dvd[k], dvs[k]);
      end
      // Everyone requests together, so service order is a plain rotation from rr_last.
      for (int i = 1; i <= 4; i++) begin
        idx = 2'((int'(rr_last) + i) % 4);
        if (mask[idx]) exp_q.push_back(idx);
      end
      req = mask;
      while (exp_q.size() > 0) begin
        idx = exp_q.pop_front();
        rr_last = idx;
        eg = 4'b0001 << idx;
        wait_sig(0, LAT + 8, n, g, d);
        n_checks++; if (n !== 1 || g !== eg) begin n_fail++; $display("FAIL rand_grant r%0d: got %b after %0d want %b after 1", rnd, g, n, eg); end
        req = req & ~eg;
        ref_div(dvd[idx], dvs[idx], eq, er, ez);
        exp_lat = ez ? 1 : LAT;
        wait_sig(1, LAT + 8, n, g, d);
        n_checks++; if (n !== exp_lat || d !== eg) begin n_fail++; $display("FAIL rand_done r%0d: got %b after %0d want %b after %0d", rnd, d, n, eg, exp_lat); end
        n_checks++; if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin n_fail++; $display("FAIL rand_result r%0d: %h/%h got q=%h r=%h dz=%b want %h %h %b", rnd, dvd[idx], dvs[idx], quotient, remainder, div_by_zero, eq, er, ez); end
      end
      req = '0;
      repeat ($urandom_range(1, 4)) tick();
    end
    n_checks++; if (onehot_viol !== 0) begin n_fail++; $display("FAIL onehot: got %0d violating cycles want 0", onehot_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_remainder_and_run_ignore();
    test_div_zero();
    test_reset_mid();
    test_self_reassert();
    test_contention();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 Port `req`, input, 4 bits: per-requester divide request, level, held until that requester's `grant`.
REQ-005 Port `req_dividend`, input, 128 bits: four packed 32-bit dividends; requester k occupies bits [32k+31:32k].
REQ-006 Port `req_divisor`, input, 64 bits: four packed 16-bit divisors; requester k occupies bits [16k+15:16k].
REQ-007 Port `grant`, output, 4 bits: one-hot, one-cycle pulse marking the requester whose operands were captured.
REQ-008 Port `done`, output, 4 bits: one-hot, one-cycle pulse marking that the result for that requester is valid.
REQ-009 Port `quotient`, output, 32 bits: quotient of the last completed operation, held until the next `done`.
REQ-010 Port `remainder`, output, 16 bits: remainder of the last completed operation, held until the next `done`.
REQ-011 Port `div_by_zero`, output, 1 bit: set when the last completed operation had a zero divisor, held like `quotient`.
REQ-012 Port `busy`, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The states SHALL be IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, if the sampled `req` (excluding the requester currently in DONE) is nonzero, the block SHALL capture the winner's operands, register `grant` for the next cycle, and move to RUN.
REQ-015 Timing: `req` sampled at edge of cycle 0 -> `grant` high in cycle 1.
REQ-016 Arbitration SHALL be round-robin: search begins at (last granted index + 1) mod 4 and wraps.
REQ-017 The last-granted pointer SHALL update only on a grant.
REQ-018 RUN SHALL execute an unsigned restoring division, 1 quotient bit per cycle, using a 17-bit partial remainder and a 5-bit iteration counter counting 31 down to 0.
REQ-019 RUN SHALL occupy cycles 1..32, then DONE in cycle 33.
REQ-020 In DONE, `done[k]` SHALL be high for exactly that cycle and `quotient`/`remainder`/`div_by_zero` SHALL be updated and valid in that cycle.
REQ-021 From DONE, the next state SHALL be RUN (new grant in cycle 34, back-to-back) or IDLE.
REQ-022 `req` from any requester during RUN SHALL be ignored.
REQ-023 A requester re-asserting `req` in its own DONE cycle SHALL be eligible from cycle 34.
REQ-024 If the captured divisor is 0, RUN SHALL be skipped (DONE in cycle 2) with `quotient` = 32'hFFFF_FFFF, `remainder` = dividend[15:0], `div_by_zero` = 1.
REQ-025 Otherwise `div_by_zero` SHALL be 0.
REQ-026 The block SHALL satisfy quotient*divisor + remainder = dividend, with remainder < divisor, for every nonzero divisor.
REQ-027 `grant` and `done` SHALL never have more than one bit set.
REQ-028 `grant` and `done` SHALL never be high in the same cycle for the same requester.

Reset
REQ-029 When `reset` is high at a clock edge, the block SHALL go to state IDLE.
REQ-030 Reset SHALL set `grant`, `done`, `quotient`, `remainder`, `div_by_zero` and `busy` to 0.
REQ-031 Reset SHALL set the last-granted pointer to 3, so requester 0 wins first.
REQ-032 Reset during RUN or DONE SHALL abort the operation with no `done` pulse, ever.
REQ-033 While `reset` is high, `req` SHALL be ignored.

Configuration
REQ-034 With macro `DIV_SCHED_RADIX4_EN` defined, RUN SHALL retire 2 quotient bits per cycle (counter 15 down to 0): RUN occupies cycles 1..16, DONE in cycle 17, back-to-back grant in cycle 18.
REQ-035 Without `DIV_SCHED_RADIX4_EN`, the 1-bit-per-cycle timing of REQ-018 and REQ-019 SHALL apply.
REQ-036 Results, arbitration order and the divide-by-zero path SHALL be identical with and without `DIV_SCHED_RADIX4_EN`.

Verification
REQ-037 Single operation: req=0001, dividend0=64_000_000, divisor0=32_000 -> grant=0001 in cycle 1; done=0001 in cycle 33 (17 with radix4); quotient=2000, remainder=0, div_by_zero=0.
REQ-038 Remainder case: req=0100, dividend2=1000, divisor2=7 -> quotient=142, remainder=6, done=0100.
REQ-039 Contention: req=1111 held after reset -> grants in order 0001, 0010, 0100, 1000, each one cycle after the preceding DONE; the four done pulses follow in the same order.
REQ-040 Divide by zero: req=1000, dividend3=32'h1234_5678, divisor3=0 -> done=1000 in cycle 2; quotient=FFFF_FFFF, remainder=5678, div_by_zero=1.
REQ-041 Reset mid-operation: reset=1 in cycle 10 of RUN for requester 1 -> no done pulse, busy=0; then req=0011 -> grant=0001 first.
REQ-042 Randomized dividends/divisors across all requesters -> results match the reference model; one-hot checks on `grant` and `done` hold throughout.
